// File: rtl/v_lane_pkg.sv
// Shared types and helpers for the vector-lane write-back path.
// Holds the lane geometry, the collector FSM encoding, the write-buffer
// entry layout and a population-count helper.
package v_lane_pkg;

  localparam int unsigned OP_WIDTH        = 32;
  localparam int unsigned PARALLEL_IF_NUM = 4;
  localparam int unsigned P               = PARALLEL_IF_NUM;
  localparam int unsigned CNT_W           = 12;
  localparam int unsigned ADDR_W          = 10;
  localparam int unsigned DATA_W          = P * OP_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } wb_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [P-1:0]      we;
    logic [ADDR_W-1:0] addr;
  } wb_entry_t;

  // Number of set bits in an interface-valid vector.
  function automatic logic [CNT_W-1:0] popcount(input logic [P-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < P; i++) n = n + CNT_W'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous write-buffer FIFO with a registered head and registered
// occupancy / free counts.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   i_push, i_data  enqueue request and payload
//   i_pop           consumer takes the head this cycle (ignored when empty)
//   o_valid, o_data registered head (data is 0 while empty)
//   o_count, o_free registered occupancy and free entries
//   o_drop_c        combinational: push refused because the FIFO is full
module wb_fifo #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [CW-1:0]    o_count,
  output logic [CW-1:0]    o_free,
  output logic             o_drop_c
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    r_free;
  logic             r_valid;
  logic [WIDTH-1:0] r_head;

  logic             w_full;
  logic             w_pop;
  logic             w_wr;
  logic [CW-1:0]    w_count_nxt;
  logic [CW-1:0]    w_left;
  logic [PW-1:0]    w_rd_nxt;
  logic [WIDTH-1:0] w_head_nxt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Occupancy update; a pop frees the slot a same-cycle push may reuse.
  always_comb begin
    w_full      = (r_count == CW'(DEPTH));
    w_pop       = i_pop && r_valid;
    w_wr        = i_push && (!w_full || w_pop);
    o_drop_c    = i_push && w_full && !w_pop;
    w_count_nxt = r_count + CW'(w_wr) - CW'(w_pop);
    w_left      = r_count - CW'(w_pop);
    w_rd_nxt    = w_pop ? ptr_inc(r_rd_ptr) : r_rd_ptr;
    // Head register is a copy of the oldest entry after this cycle.
    if (w_count_nxt == '0)   w_head_nxt = '0;
    else if (w_left == '0)   w_head_nxt = i_data;
    else                     w_head_nxt = r_mem[w_rd_nxt];
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_free   <= CW'(DEPTH);
      r_valid  <= 1'b0;
      r_head   <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= ptr_inc(r_wr_ptr);
      r_rd_ptr <= w_rd_nxt;
      r_count  <= w_count_nxt;
      r_free   <= CW'(DEPTH) - w_count_nxt;
      r_valid  <= (w_count_nxt != '0);
      r_head   <= w_head_nxt;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_head;
  assign o_count = r_count;
  assign o_free  = r_free;

endmodule

// File: rtl/alu_result_collector.sv
// Write-back collector for the vector-lane ALU: gathers per-interface
// results (data mode) or compare bits packed into mask words (mask mode),
// buffers them and issues VRF writes at incrementing addresses.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   start_i, vl_i, mask_mode_i,
//   waddr_base_i                    instruction launch (sampled in IDLE)
//   alu_data_i, alu_vld_i,
//   alu_mask_i                      ALU result interfaces
//   alu_accept_o                    room for a full ALU pipeline plus one
//   vrf_wvalid_o/wready_i/waddr_o/
//   wdata_o/we_o                    VRF write port
//   busy_o, done_o, overflow_o      status
module alu_result_collector
  import v_lane_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned ALU_LAT    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  vl_i,
  input  logic              mask_mode_i,
  input  logic [ADDR_W-1:0] waddr_base_i,
  input  logic [DATA_W-1:0] alu_data_i,
  input  logic [P-1:0]      alu_vld_i,
  input  logic [P-1:0]      alu_mask_i,
  output logic              alu_accept_o,
  output logic              vrf_wvalid_o,
  input  logic              vrf_wready_i,
  output logic [ADDR_W-1:0] vrf_waddr_o,
  output logic [DATA_W-1:0] vrf_wdata_o,
  output logic [P-1:0]      vrf_we_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              overflow_o
);

  localparam int unsigned FCW     = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned GRPS    = OP_WIDTH / P;
  localparam int unsigned GW      = (GRPS > 1) ? $clog2(GRPS) : 1;
  localparam int unsigned ENTRY_W = $bits(wb_entry_t);

  wb_state_e           r_state,    w_state_nxt;
  logic [CNT_W-1:0]    r_vl,       w_vl_nxt;
  logic                r_mode,     w_mode_nxt;
  logic [ADDR_W-1:0]   r_addr,     w_addr_nxt;
  logic [CNT_W-1:0]    r_cnt,      w_cnt_nxt;
  logic [OP_WIDTH-1:0] r_word,     w_word_nxt;
  logic [GW-1:0]       r_grp,      w_grp_nxt;
  logic                r_overflow, w_overflow_nxt;
  logic                r_done,     w_done_nxt;
  logic                r_busy,     w_busy_nxt;

  logic [CNT_W-1:0]    w_rem;
  logic [CNT_W-1:0]    w_seen;
  logic [P-1:0]        w_vld;
  logic                w_any;
  logic [CNT_W-1:0]    w_cnt_sum;
  logic                w_last;
  logic [OP_WIDTH-1:0] w_word;
  logic [DATA_W-1:0]   w_lane_data;
  logic                w_drained;

  wb_entry_t           w_push_entry;
  wb_entry_t           w_head;
  logic                w_push;
  logic                w_pop;
  logic                w_drop;
  logic                w_fifo_vld;
  logic [FCW-1:0]      w_fifo_cnt;
  logic [FCW-1:0]      w_fifo_free;

  wb_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .i_push   (w_push),
    .i_data   (w_push_entry),
    .i_pop    (w_pop),
    .o_valid  (w_fifo_vld),
    .o_data   (w_head),
    .o_count  (w_fifo_cnt),
    .o_free   (w_fifo_free),
    .o_drop_c (w_drop)
  );

  // Keep only RUN-phase valid bits that still fit within vl, in lane order.
  always_comb begin
    w_rem  = r_vl - r_cnt;
    w_seen = '0;
    w_vld  = '0;
    for (int i = 0; i < P; i++) begin
      if (alu_vld_i[i]) begin
        w_seen = w_seen + CNT_W'(1);
        if ((r_state == ST_RUN) && (w_seen <= w_rem)) w_vld[i] = 1'b1;
      end
    end
  end

  // Group bookkeeping shared by both modes.
  always_comb begin
    w_any       = |w_vld;
    w_cnt_sum   = r_cnt + popcount(w_vld);
    w_last      = w_any && (w_cnt_sum == r_vl);
    w_word      = r_word | (OP_WIDTH'(alu_mask_i & w_vld) << (P * r_grp));
    w_lane_data = '0;
    for (int i = 0; i < P; i++) begin
      if (w_vld[i]) w_lane_data[i*OP_WIDTH +: OP_WIDTH] = alu_data_i[i*OP_WIDTH +: OP_WIDTH];
    end
    w_pop     = vrf_wvalid_o && vrf_wready_i;
    w_drained = (w_fifo_cnt == '0) || ((w_fifo_cnt == FCW'(1)) && w_pop);
  end

  // Next-state and push generation.
  always_comb begin
    w_state_nxt    = r_state;
    w_vl_nxt       = r_vl;
    w_mode_nxt     = r_mode;
    w_addr_nxt     = r_addr;
    w_cnt_nxt      = r_cnt;
    w_word_nxt     = r_word;
    w_grp_nxt      = r_grp;
    w_overflow_nxt = r_overflow;
    w_done_nxt     = 1'b0;
    w_push         = 1'b0;
    w_push_entry   = '0;

    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          w_vl_nxt       = vl_i;
          w_mode_nxt     = mask_mode_i;
          w_addr_nxt     = waddr_base_i;
          w_cnt_nxt      = '0;
          w_word_nxt     = '0;
          w_grp_nxt      = '0;
          w_overflow_nxt = 1'b0;
          w_state_nxt    = (vl_i == '0) ? ST_DRAIN : ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_any) begin
          w_cnt_nxt = w_cnt_sum;
          if (!r_mode) begin
            w_push            = 1'b1;
            w_push_entry.data = w_lane_data;
            w_push_entry.we   = w_vld;
            w_push_entry.addr = r_addr;
          end else if ((r_grp == GW'(GRPS - 1)) || w_last) begin
            // Full or final partial mask word goes out in interface 0.
            w_push            = 1'b1;
            w_push_entry.data = DATA_W'(w_word);
            w_push_entry.we   = P'(1);
            w_push_entry.addr = r_addr;
            w_word_nxt        = '0;
            w_grp_nxt         = '0;
          end else begin
            w_word_nxt = w_word;
            w_grp_nxt  = r_grp + GW'(1);
          end
          if (w_last) w_state_nxt = ST_DRAIN;
        end
        if (w_push) w_addr_nxt = r_addr + ADDR_W'(1);
        if (w_drop) w_overflow_nxt = 1'b1;
      end
      ST_DRAIN: begin
        if (w_drained) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_vl       <= '0;
      r_mode     <= 1'b0;
      r_addr     <= '0;
      r_cnt      <= '0;
      r_word     <= '0;
      r_grp      <= '0;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_vl       <= w_vl_nxt;
      r_mode     <= w_mode_nxt;
      r_addr     <= w_addr_nxt;
      r_cnt      <= w_cnt_nxt;
      r_word     <= w_word_nxt;
      r_grp      <= w_grp_nxt;
      r_overflow <= w_overflow_nxt;
      r_done     <= w_done_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  // Accept only while a full ALU pipeline of results plus one more still fits.
  assign alu_accept_o = (w_fifo_free >= FCW'(ALU_LAT + 1));
  assign vrf_wvalid_o = w_fifo_vld;
  assign vrf_waddr_o  = w_head.addr;
  assign vrf_wdata_o  = w_head.data;
  assign vrf_we_o     = w_head.we;
  assign busy_o       = r_busy;
  assign done_o       = r_done;
  assign overflow_o   = r_overflow;

endmodule

// File: tb/tb_alu_result_collector.sv
// Scoreboard bench for alu_result_collector: expected VRF writes are queued
// as ALU groups are driven and checked in order as writes transfer.
module tb_alu_result_collector;
  import v_lane_pkg::*;

  localparam int unsigned DW = DATA_W;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [P-1:0]      we;
    logic [DW-1:0]     data;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start_i = 1'b0;
  logic [CNT_W-1:0]  vl_i = '0;
  logic              mask_mode_i = 1'b0;
  logic [ADDR_W-1:0] waddr_base_i = '0;
  logic [DW-1:0]     alu_data_i = '0;
  logic [P-1:0]      alu_vld_i = '0;
  logic [P-1:0]      alu_mask_i = '0;
  logic              alu_accept_o;
  logic              vrf_wvalid_o;
  logic              vrf_wready_i = 1'b0;
  logic [ADDR_W-1:0] vrf_waddr_o;
  logic [DW-1:0]     vrf_wdata_o;
  logic [P-1:0]      vrf_we_o;
  logic              busy_o;
  logic              done_o;
  logic              overflow_o;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_wr_cyc = 0;
  int   n_wr = 0;

  alu_result_collector #(.FIFO_DEPTH(8), .ALU_LAT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .vl_i         (vl_i),
    .mask_mode_i  (mask_mode_i),
    .waddr_base_i (waddr_base_i),
    .alu_data_i   (alu_data_i),
    .alu_vld_i    (alu_vld_i),
    .alu_mask_i   (alu_mask_i),
    .alu_accept_o (alu_accept_o),
    .vrf_wvalid_o (vrf_wvalid_o),
    .vrf_wready_i (vrf_wready_i),
    .vrf_waddr_o  (vrf_waddr_o),
    .vrf_wdata_o  (vrf_wdata_o),
    .vrf_we_o     (vrf_we_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .overflow_o   (overflow_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] lanes(input logic [P-1:0] we);
    logic [DW-1:0] m;
    m = '0;
    for (int i = 0; i < P; i++) if (we[i]) m[i*OP_WIDTH +: OP_WIDTH] = '1;
    return m;
  endfunction

  function automatic logic [DW-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [ADDR_W-1:0] a, input logic [P-1:0] we, input logic [DW-1:0] d);
    exp_t e;
    e.addr = a;
    e.we   = we;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic start_instr(input int vl, input logic mode, input logic [ADDR_W-1:0] base);
    start_i      = 1'b1;
    vl_i         = CNT_W'(vl);
    mask_mode_i  = mode;
    waddr_base_i = base;
    tick();
    start_i = 1'b0;
  endtask

  task automatic drive_group(input logic [P-1:0] vld, input logic [P-1:0] msk, input logic [DW-1:0] d);
    alu_vld_i  = vld;
    alu_mask_i = msk;
    alu_data_i = d;
    tick();
    alu_vld_i  = '0;
    alu_mask_i = '0;
  endtask

  // Wait (bounded) for done_o; check it arrived and its latency from a reference cycle.
  task automatic wait_done(input string tag, input logic from_wr, input int ref_cyc, input int lat);
    int n;
    int r;
    n = 0;
    @(negedge clk);
    while (!done_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    r = from_wr ? last_wr_cyc : ref_cyc;
    chk({tag, "_done"}, DW'(done_o), DW'(1));
    chk({tag, "_lat"}, DW'(cyc - r), DW'(lat));
    chk({tag, "_sb_empty"}, DW'(sb.size()), DW'(0));
    tick();
  endtask

  // Write monitor: every transfer must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && vrf_wvalid_o && vrf_wready_i) begin
      n_wr++;
      last_wr_cyc = cyc;
      if (sb.size() == 0) begin
        chk("wr_unexpected", DW'(vrf_wvalid_o), DW'(0));
      end else begin
        mon_e = sb.pop_front();
        chk("waddr", DW'(vrf_waddr_o), DW'(mon_e.addr));
        chk("we", DW'(vrf_we_o), DW'(mon_e.we));
        chk("wdata", vrf_wdata_o & lanes(mon_e.we), mon_e.data & lanes(mon_e.we));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    int c0;
    int n0;

    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_wvalid", DW'(vrf_wvalid_o), DW'(0));
    chk("rst_we", DW'(vrf_we_o), DW'(0));
    chk("rst_waddr", DW'(vrf_waddr_o), DW'(0));
    chk("rst_wdata", vrf_wdata_o, DW'(0));
    chk("rst_busy", DW'(busy_o), DW'(0));
    chk("rst_done", DW'(done_o), DW'(0));
    chk("rst_ovf", DW'(overflow_o), DW'(0));
    chk("rst_accept", DW'(alu_accept_o), DW'(1));

    // Data mode, two full groups
    vrf_wready_i = 1'b1;
    d0 = rnd();
    d1 = rnd();
    start_instr(8, 1'b0, 10'h010);
    chk("dfull_busy", DW'(busy_o), DW'(1));
    expect_wr(10'h010, 4'hF, d0);
    drive_group(4'hF, 4'h0, d0);
    expect_wr(10'h011, 4'hF, d1);
    drive_group(4'hF, 4'h0, d1);
    wait_done("dfull", 1'b1, 0, 1);
    chk("dfull_idle", DW'(busy_o), DW'(0));

    // Data mode, partial final group
    d0 = rnd();
    d1 = rnd();
    start_instr(6, 1'b0, 10'h020);
    expect_wr(10'h020, 4'hF, d0);
    drive_group(4'hF, 4'h0, d0);
    expect_wr(10'h021, 4'h3, d1);
    drive_group(4'hF, 4'h0, d1);
    wait_done("dpart", 1'b1, 0, 1);

    // Mask mode, one full word
    start_instr(32, 1'b1, 10'h030);
    expect_wr(10'h030, 4'b0001, DW'(32'hAAAA_AAAA));
    for (int g = 0; g < 8; g++) drive_group(4'hF, 4'hA, rnd());
    wait_done("mfull", 1'b1, 0, 1);

    // Mask mode, partial word
    start_instr(5, 1'b1, 10'h040);
    expect_wr(10'h040, 4'b0001, DW'(32'h0000_001F));
    drive_group(4'hF, 4'hF, rnd());
    drive_group(4'hF, 4'h1, rnd());
    wait_done("mpart", 1'b1, 0, 1);

    // vl == 0: done two cycles after start, no write
    n0 = n_wr;
    c0 = cyc;
    start_instr(0, 1'b0, 10'h0F0);
    wait_done("vl0", 1'b0, c0, 2);
    chk("vl0_no_wr", DW'(n_wr - n0), DW'(0));

    // Backpressure: accept drops after 4 entries, 9th push overflows
    vrf_wready_i = 1'b0;
    start_instr(40, 1'b0, 10'h050);
    for (int k = 1; k <= 9; k++) begin
      d0 = rnd();
      if (k <= 8) expect_wr(ADDR_W'(32'h50 + k - 1), 4'hF, d0);
      drive_group(4'hF, 4'h0, d0);
      chk($sformatf("bp_accept_%0d", k), DW'(alu_accept_o), DW'(k <= 3));
      chk($sformatf("bp_ovf_%0d", k), DW'(overflow_o), DW'(k == 9));
    end
    chk("bp_hold_addr", DW'(vrf_waddr_o), DW'(10'h050));
    chk("bp_hold_valid", DW'(vrf_wvalid_o), DW'(1));
    vrf_wready_i = 1'b1;
    for (int n = 0; n < 30 && sb.size() != 0; n++) tick();
    chk("bp_drained", DW'(sb.size()), DW'(0));
    chk("bp_ovf_sticky", DW'(overflow_o), DW'(1));

    // Reset mid-RUN with entries buffered
    vrf_wready_i = 1'b0;
    drive_group(4'h1, 4'h0, rnd());
    drive_group(4'h1, 4'h0, rnd());
    chk("mrst_busy_before", DW'(busy_o), DW'(1));
    rst = 1'b1;
    tick();
    chk("mrst_wvalid", DW'(vrf_wvalid_o), DW'(0));
    chk("mrst_we", DW'(vrf_we_o), DW'(0));
    chk("mrst_waddr", DW'(vrf_waddr_o), DW'(0));
    chk("mrst_wdata", vrf_wdata_o, DW'(0));
    chk("mrst_busy", DW'(busy_o), DW'(0));
    chk("mrst_done", DW'(done_o), DW'(0));
    chk("mrst_ovf", DW'(overflow_o), DW'(0));
    chk("mrst_accept", DW'(alu_accept_o), DW'(1));
    rst = 1'b0;
    vrf_wready_i = 1'b1;
    n0 = n_wr;
    repeat (10) tick();
    chk("mrst_no_wr", DW'(n_wr - n0), DW'(0));

    // Recovery with address wrap-around
    d0 = rnd();
    d1 = rnd();
    start_instr(8, 1'b0, 10'h3FF);
    expect_wr(10'h3FF, 4'hF, d0);
    drive_group(4'hF, 4'h0, d0);
    expect_wr(10'h000, 4'hF, d1);
    drive_group(4'hF, 4'h0, d1);
    wait_done("wrap", 1'b1, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
